// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/status bundle between mc_ctrl and the CPU datapath
// master: the controller (reads IR fields, ALU zero, DM ready; drives enables/selects)
// slave : the datapath side (drives IR fields, zero, mem_ready; consumes controls)
interface mc_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  EOp;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        illegal;
    logic        mem_err;
    logic [2:0]  state_o;
    logic [31:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ir_we, pc_we, pc_sel, EOp, alu_src, alu_op, mem_req, mem_we,
               reg_we, reg_dst, wd_sel, illegal, mem_err, state_o, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ir_we, pc_we, pc_sel, EOp, alu_src, alu_op, mem_req, mem_we,
               reg_we, reg_dst, wd_sel, illegal, mem_err, state_o, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the MIPS-subset CPU
// clk   : system clock, rising edge
// reset : asynchronous, active-high
// bus   : mc_ctrl_if.master - opcode/funct/zero/mem_ready in; IR/PC/GRF/DM enables,
//         pc_sel, EOp, alu_src, alu_op, reg_dst, wd_sel, illegal/mem_err pulses,
//         state_o and retired-instruction count out
// TIMEOUT_W : MEM watchdog width; access aborted after 2**TIMEOUT_W-1 stalled cycles
module mc_ctrl #(
    parameter int TIMEOUT_W = 4
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t               state, state_nx;
    logic [TIMEOUT_W-1:0] wdog, wdog_nx;
    logic [31:0]          retired_q;
    logic                 retire;

    logic is_r, is_addu, is_subu, is_jr, is_nop, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

    logic       ir_we, pc_we, alu_src, mem_req, mem_we, reg_we, illegal, mem_err;
    logic [1:0] pc_sel, eop, reg_dst, wd_sel;
    logic [2:0] alu_op;

    assign is_r     = (bus.opcode == OP_RTYPE);
    assign is_addu  = is_r && (bus.funct == FN_ADDU);
    assign is_subu  = is_r && (bus.funct == FN_SUBU);
    assign is_jr    = is_r && (bus.funct == FN_JR);
    // Only opcode and funct are visible here, so an all-zero IR is recognised
    // as R-type with funct 0.
    assign is_nop   = is_r && (bus.funct == FN_NOP);
    assign is_ori   = (bus.opcode == OP_ORI);
    assign is_lui   = (bus.opcode == OP_LUI);
    assign is_lw    = (bus.opcode == OP_LW);
    assign is_sw    = (bus.opcode == OP_SW);
    assign is_beq   = (bus.opcode == OP_BEQ);
    assign is_j     = (bus.opcode == OP_J);
    assign is_jal   = (bus.opcode == OP_JAL);
    assign is_legal = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j | is_jal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            wdog      <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nx;
            wdog  <= wdog_nx;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_nx = S_FETCH;
        wdog_nx  = wdog;
        retire   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        eop      = 2'b00;
        alu_src  = 1'b0;
        alu_op   = 3'b000;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        reg_dst  = 2'b00;
        wd_sel   = 2'b00;
        illegal  = 1'b0;
        mem_err  = 1'b0;

        // Extender mode follows the opcode everywhere except FETCH, where the
        // IR still holds the previous instruction.
        if (state != S_FETCH) begin
            if (is_ori) begin
                eop = 2'b01;
            end else if (is_lui) begin
                eop = 2'b10;
            end else if (is_beq) begin
                eop = 2'b11;
            end
        end

        case (state)
            S_FETCH: begin
                ir_we    = 1'b1;
                pc_we    = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'b10;
                    retire = 1'b1;
                end else if (is_jal) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'b10;
                    reg_we  = 1'b1;
                    reg_dst = 2'b10;
                    wd_sel  = 2'b10;
                    retire  = 1'b1;
                end else if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'b11;
                    retire = 1'b1;
                end else if (is_nop) begin
                    retire = 1'b1;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_addu) begin
                    state_nx = S_WB;
                end else if (is_subu) begin
                    alu_op   = 3'b001;
                    state_nx = S_WB;
                end else if (is_ori) begin
                    alu_op   = 3'b010;
                    alu_src  = 1'b1;
                    state_nx = S_WB;
                end else if (is_lui) begin
                    alu_op   = 3'b011;
                    alu_src  = 1'b1;
                    state_nx = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src  = 1'b1;
                    wdog_nx  = '0;
                    state_nx = S_MEM;
                end else if (is_beq) begin
                    alu_op = 3'b001;
                    retire = 1'b1;
                    if (bus.zero) begin
                        pc_we  = 1'b1;
                        pc_sel = 2'b01;
                    end
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                // A completing access takes priority over watchdog expiry.
                if (bus.mem_ready) begin
                    if (is_sw) begin
                        retire = 1'b1;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (wdog == WDOG_MAX) begin
                    mem_err = 1'b1;
                end else begin
                    wdog_nx  = wdog + WDOG_ONE;
                    state_nx = S_MEM;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = (is_addu || is_subu) ? 2'b01 : 2'b00;
                wd_sel  = is_lw ? 2'b01 : 2'b00;
                retire  = 1'b1;
            end
            default: ;
        endcase

        // The state register already reads FETCH during reset; mask the strobes
        // so nothing is written while reset is held.
        if (reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            illegal = 1'b0;
            mem_err = 1'b0;
        end
    end

    assign bus.ir_we   = ir_we;
    assign bus.pc_we   = pc_we;
    assign bus.pc_sel  = pc_sel;
    assign bus.EOp     = eop;
    assign bus.alu_src = alu_src;
    assign bus.alu_op  = alu_op;
    assign bus.mem_req = mem_req;
    assign bus.mem_we  = mem_we;
    assign bus.reg_we  = reg_we;
    assign bus.reg_dst = reg_dst;
    assign bus.wd_sel  = wd_sel;
    assign bus.illegal = illegal;
    assign bus.mem_err = mem_err;
    assign bus.state_o = state;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;
    localparam int TW    = 2;
    localparam int LIMIT = (1 << TW) - 1;

    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_NOP = 3, C_ORI = 4, C_LUI = 5;
    localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_J = 9, C_JAL = 10, C_ILL = 11;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic [1:0]  eop;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic        mem_req;
        logic        mem_we;
        logic        reg_we;
        logic [1:0]  reg_dst;
        logic [1:0]  wd_sel;
        logic        illegal;
        logic        mem_err;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } item_t;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if bus();

    mc_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    item_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          ncyc = 0;
    logic [31:0] model_ret = 0;
    int          n_req = 0;
    int          n_err = 0;
    int          n_ill = 0;
    item_t       cur_it;
    exp_t        cur_act;

    function automatic int classify(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: return C_ADDU;
                    6'b100011: return C_SUBU;
                    6'b001000: return C_JR;
                    6'b000000: return C_NOP;
                    default:   return C_ILL;
                endcase
            end
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] ext_mode(int c);
        if (c == C_ORI) return 2'b01;
        if (c == C_LUI) return 2'b10;
        if (c == C_BEQ) return 2'b11;
        return 2'b00;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.ret = model_ret;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.st      = bus.state_o;
        a.ir_we   = bus.ir_we;
        a.pc_we   = bus.pc_we;
        a.pc_sel  = bus.pc_sel;
        a.eop     = bus.EOp;
        a.alu_src = bus.alu_src;
        a.alu_op  = bus.alu_op;
        a.mem_req = bus.mem_req;
        a.mem_we  = bus.mem_we;
        a.reg_we  = bus.reg_we;
        a.reg_dst = bus.reg_dst;
        a.wd_sel  = bus.wd_sel;
        a.illegal = bus.illegal;
        a.mem_err = bus.mem_err;
        a.ret     = bus.retired;
        return a;
    endfunction

    task automatic check(string nm, exp_t act, exp_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic lit(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    // Compare every cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur_it  = q.pop_front();
            cur_act = sample();
            check(cur_it.tag, cur_act, cur_it.e);
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req) n_req <= n_req + 1;
        if (bus.mem_err) n_err <= n_err + 1;
        if (bus.illegal) n_ill <= n_ill + 1;
    end

    // One clock cycle: apply inputs, queue what the outputs must be, advance.
    task automatic drive(string tag, logic rst, logic [5:0] op, logic [5:0] fn,
                         logic z, logic rdy, exp_t e);
        item_t it;
        reset         = rst;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        it.e   = e;
        it.tag = $sformatf("%s_c%0d", tag, ncyc);
        q.push_back(it);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc(string tag);
        exp_t e;
        model_ret = 0;
        ncyc = 0;
        e = blank();
        drive(tag, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, e);
    endtask

    // Expected per-cycle trace of one instruction, built from the instruction
    // class; stalls = cycles of mem_ready low before it rises; cut>0 stops
    // after that many cycles (instruction abandoned).
    task automatic run(string tag, logic [5:0] op, logic [5:0] fn, logic z,
                       int stalls, int cut);
        int   c;
        exp_t e;
        logic rdy;
        c = classify(op, fn);
        ncyc = 0;

        e = blank();
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        drive(tag, 1'b0, op, fn, z, 1'b0, e);
        if (cut == ncyc) return;

        e = blank();
        e.st  = 3'd1;
        e.eop = ext_mode(c);
        case (c)
            C_J:   begin e.pc_we = 1'b1; e.pc_sel = 2'b10; end
            C_JAL: begin
                e.pc_we = 1'b1; e.pc_sel = 2'b10;
                e.reg_we = 1'b1; e.reg_dst = 2'b10; e.wd_sel = 2'b10;
            end
            C_JR:  begin e.pc_we = 1'b1; e.pc_sel = 2'b11; end
            C_ILL: e.illegal = 1'b1;
            default: ;
        endcase
        drive(tag, 1'b0, op, fn, z, 1'b0, e);
        if (c == C_J || c == C_JAL || c == C_JR || c == C_NOP) begin
            model_ret++;
            return;
        end
        if (c == C_ILL || cut == ncyc) return;

        e = blank();
        e.st  = 3'd2;
        e.eop = ext_mode(c);
        case (c)
            C_SUBU: e.alu_op = 3'b001;
            C_ORI:  begin e.alu_op = 3'b010; e.alu_src = 1'b1; end
            C_LUI:  begin e.alu_op = 3'b011; e.alu_src = 1'b1; end
            C_LW, C_SW: e.alu_src = 1'b1;
            C_BEQ: begin
                e.alu_op = 3'b001;
                if (z) begin e.pc_we = 1'b1; e.pc_sel = 2'b01; end
            end
            default: ;
        endcase
        drive(tag, 1'b0, op, fn, z, 1'b0, e);
        if (c == C_BEQ) begin
            model_ret++;
            return;
        end
        if (cut == ncyc) return;

        if (c == C_LW || c == C_SW) begin
            for (int k = 0; k <= LIMIT; k++) begin
                rdy = (k >= stalls);
                e = blank();
                e.st      = 3'd3;
                e.eop     = ext_mode(c);
                e.mem_req = 1'b1;
                e.mem_we  = (c == C_SW);
                e.mem_err = !rdy && (k == LIMIT);
                drive(tag, 1'b0, op, fn, z, rdy, e);
                if (e.mem_err) return;
                if (rdy) break;
                if (cut == ncyc) return;
            end
            if (c == C_SW) begin
                model_ret++;
                return;
            end
        end

        e = blank();
        e.st      = 3'd4;
        e.eop     = ext_mode(c);
        e.reg_we  = 1'b1;
        e.reg_dst = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
        e.wd_sel  = (c == C_LW) ? 2'b01 : 2'b00;
        drive(tag, 1'b0, op, fn, z, 1'b0, e);
        model_ret++;
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        rst_cyc("reset_a");
        rst_cyc("reset_b");

        run("ori",     6'b001101, 6'b000000, 1'b0, 0, 0);
        run("addu",    6'b000000, 6'b100001, 1'b0, 0, 0);
        run("subu",    6'b000000, 6'b100011, 1'b0, 0, 0);
        run("lui",     6'b001111, 6'b000000, 1'b0, 0, 0);
        lit("ret_after_lui", bus.retired, 32'd4);
        run("lw_st3",  6'b100011, 6'b000000, 1'b0, 3, 0);
        lit("ret_after_lw_st3", bus.retired, 32'd5);
        run("lw_st0",  6'b100011, 6'b000000, 1'b0, 0, 0);
        run("sw_st0",  6'b101011, 6'b000000, 1'b0, 0, 0);
        run("sw_tmo",  6'b101011, 6'b000000, 1'b0, 10, 0);
        lit("ret_after_tmo", bus.retired, 32'd7);
        lit("state_after_tmo", {29'd0, bus.state_o}, 32'd0);
        run("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0);
        run("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0);
        run("j",       6'b000010, 6'b000000, 1'b0, 0, 0);
        run("jal",     6'b000011, 6'b000000, 1'b0, 0, 0);
        run("jr",      6'b000000, 6'b001000, 1'b0, 0, 0);
        run("nop",     6'b000000, 6'b000000, 1'b0, 0, 0);
        lit("ret_after_nop", bus.retired, 32'd13);
        run("ill_op",  6'b111111, 6'b000000, 1'b0, 0, 0);
        run("ill_fn",  6'b000000, 6'b000001, 1'b0, 0, 0);
        lit("ret_after_ill", bus.retired, 32'd13);
        run("sw_cut",  6'b101011, 6'b000000, 1'b0, 10, 4);
        lit("ret_before_rst", bus.retired, 32'd13);
        rst_cyc("rst_mid_mem");
        lit("ret_after_rst", bus.retired, 32'd0);
        run("ori_post", 6'b001101, 6'b000000, 1'b0, 0, 0);
        lit("ret_final", bus.retired, 32'd1);
        lit("mem_req_cycles", n_req, 32'd11);
        lit("mem_err_pulses", n_err, 32'd1);
        lit("illegal_pulses", n_ill, 32'd2);
        lit("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
